// File: rtl/aes_word_feeder_if.sv
// aes_word_feeder_if: word bus, result port, status and cipher-core signals of the word feeder.
// The feeder is the slave side. The bus master and the cipher core sit on the master side.
interface aes_word_feeder_if;
    logic         in_valid;
    logic         in_ready;
    logic         in_sel;
    logic [31:0]  in_word;
    logic         key_valid;
    logic         err_nokey;
    logic [127:0] cipher_datain;
    logic [127:0] cipher_key;
    logic [127:0] cipher_dataout;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_block;
    modport slave (
        input  in_valid, in_sel, in_word, cipher_dataout, out_ready,
        output in_ready, key_valid, err_nokey, cipher_datain, cipher_key, out_valid, out_block
    );
    modport master (
        output in_valid, in_sel, in_word, cipher_dataout, out_ready,
        input  in_ready, key_valid, err_nokey, cipher_datain, cipher_key, out_valid, out_block
    );
endinterface

// File: rtl/aes_word_feeder.sv
// aes_word_feeder: assembles 32-bit key/plaintext words for a combinational AES-128 core.
// It holds the core inputs for SETTLE_CYCLES clocks, then captures the result and offers it on a valid/ready port.
module aes_word_feeder #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    aes_word_feeder_if.slave  bus
);
    typedef enum logic [1:0] {LOAD, WAIT, OUT} state_t;
    state_t       r_state, w_next;
    logic [95:0]  r_ksreg, r_dsreg;
    logic [1:0]   r_kcnt, r_dcnt;
    logic [3:0]   r_wcnt;
    logic         r_in_ready, r_key_valid, r_err, r_out_valid;
    logic [127:0] r_key, r_datain, r_block;
    logic         w_acc, w_key_acc, w_dat_acc, w_launch, w_capture, w_handshake;
    assign w_acc       = bus.in_valid & r_in_ready;
    assign w_key_acc   = w_acc & bus.in_sel;
    assign w_dat_acc   = w_acc & ~bus.in_sel & r_key_valid;
    assign w_launch    = w_dat_acc & (r_dcnt == 2'd3);
    assign w_capture   = (r_state == WAIT) & (r_wcnt == 4'd1);
    assign w_handshake = r_out_valid & bus.out_ready;
    // in_ready is only ever high in LOAD, so launch, capture and handshake are mutually exclusive
    always_comb begin
        w_next = r_state;
        w_next = w_launch ? WAIT : w_capture ? OUT : w_handshake ? LOAD : r_state;
    end
    always_ff @(posedge clk) begin
        if (rst) r_state <= LOAD;
        else     r_state <= w_next;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_ready  <= 1'b0;
            r_key_valid <= 1'b0;
            r_err       <= 1'b0;
            r_out_valid <= 1'b0;
            r_ksreg     <= '0;
            r_dsreg     <= '0;
            r_kcnt      <= '0;
            r_dcnt      <= '0;
            r_wcnt      <= '0;
            r_key       <= '0;
            r_datain    <= '0;
            r_block     <= '0;
        end else begin
            r_in_ready <= (w_next == LOAD);
            r_err      <= w_acc & ~bus.in_sel & ~r_key_valid;
            if (w_key_acc) begin
                r_ksreg <= {r_ksreg[63:0], bus.in_word};
                r_kcnt  <= r_kcnt + 2'd1;
                if (r_kcnt == 2'd3) begin
                    r_key       <= {r_ksreg, bus.in_word};
                    r_key_valid <= 1'b1;
                end
            end
            if (w_dat_acc) begin
                r_dsreg <= {r_dsreg[63:0], bus.in_word};
                r_dcnt  <= r_dcnt + 2'd1;
                if (w_launch) r_datain <= {r_dsreg, bus.in_word};
            end
            if (w_launch)              r_wcnt <= 4'(SETTLE_CYCLES);
            else if (r_state == WAIT)  r_wcnt <= r_wcnt - 4'd1;
            if (w_capture) begin
                r_block     <= bus.cipher_dataout;
                r_out_valid <= 1'b1;
            end else if (w_handshake) begin
                r_out_valid <= 1'b0;
            end
        end
    end
    assign bus.in_ready      = r_in_ready;
    assign bus.key_valid     = r_key_valid;
    assign bus.err_nokey     = r_err;
    assign bus.cipher_key    = r_key;
    assign bus.cipher_datain = r_datain;
    assign bus.out_valid     = r_out_valid;
    assign bus.out_block     = r_block;
endmodule
